sram_dp: RTL and testbench

- Single-clock, true dual-port, byte-writable block RAM for the pipeline.
- Next generation of the single-port byte-enable SRAM. Adds:
  - a second independent read/write port;
  - a selectable same-port read mode;
  - an optional output register;
  - read-valid tracking;
  - a post-reset clear sequencer.
- Used for I/D memories and register-like tables that need two simultaneous accesses per cycle.

---
 rtl/sram_pkg.sv | 32 +++
 rtl/sram_dp_if.sv | 29 ++
 rtl/sram_port_out.sv | 78 +++++++
 rtl/sram_dp.sv | 120 ++++++++++++
 tb/tb_sram_dp.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the dual-port byte-writable SRAM.
package sram_pkg;

  // Same-port read-during-write behaviour.
  typedef enum logic [1:0] {
    WM_WRITE_FIRST = 2'd0,
    WM_READ_FIRST  = 2'd1,
    WM_NO_CHANGE   = 2'd2
  } write_mode_e;

  // Post-reset clear sequencer states.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Widest supported data path: 64 byte lanes (512 bits).
  localparam int MAX_LANES  = 64;
  localparam int MAX_MASK_W = 8 * MAX_LANES;

  // Expand one write-enable bit per byte lane into an 8-bit lane mask.
  // Callers zero-extend their enables and truncate the result to their width.
  function automatic logic [MAX_MASK_W-1:0] byte_mask(input logic [MAX_LANES-1:0] we);
    logic [MAX_MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      m[8*i +: 8] = {8{we[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_dp_if.sv
// Two-port access bundle for sram_dp: request side from the master, result side from the RAM.
interface sram_dp_if #(
  parameter int LEN_ADDR = 32,
  parameter int LEN_DATA = 32
);
  logic                  a_en;
  logic [LEN_DATA/8-1:0] a_we;
  logic [LEN_ADDR-1:0]   a_addr;
  logic [LEN_DATA-1:0]   a_wdata;
  logic [LEN_DATA-1:0]   a_rdata;
  logic                  a_rvalid;

  logic                  b_en;
  logic [LEN_DATA/8-1:0] b_we;
  logic [LEN_ADDR-1:0]   b_addr;
  logic [LEN_DATA-1:0]   b_wdata;
  logic [LEN_DATA-1:0]   b_rdata;
  logic                  b_rvalid;

  modport master (
    output a_en, a_we, a_addr, a_wdata, b_en, b_we, b_addr, b_wdata,
    input  a_rdata, a_rvalid, b_rdata, b_rvalid
  );

  modport slave (
    input  a_en, a_we, a_addr, a_wdata, b_en, b_we, b_addr, b_wdata,
    output a_rdata, a_rvalid, b_rdata, b_rvalid
  );
endinterface

// File: rtl/sram_port_out.sv
// Per-port result path: picks the read result for the write mode, registers it,
// and optionally adds a second pipeline stage.
module sram_port_out #(
  parameter int LEN_DATA   = 32,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_acc,
  input  logic                i_write,
  input  logic [LEN_DATA-1:0] i_old,
  input  logic [LEN_DATA-1:0] i_merged,
  output logic [LEN_DATA-1:0] o_rdata,
  output logic                o_rvalid
);
  import sram_pkg::*;

  localparam write_mode_e WM = write_mode_e'(WRITE_MODE);

  logic [LEN_DATA-1:0] w_s1_data;
  logic [LEN_DATA-1:0] r_s1_data;
  logic                r_s1_valid;

  // Select the value the first result stage takes this cycle.
  always_comb begin
    w_s1_data = '0;
    if (i_acc) begin
      if (!i_write) begin
        w_s1_data = i_old;
      end else begin
        case (WM)
          WM_WRITE_FIRST: w_s1_data = i_merged;
          WM_READ_FIRST:  w_s1_data = i_old;
          default:        w_s1_data = r_s1_data;
        endcase
      end
    end else if (WM == WM_NO_CHANGE) begin
      w_s1_data = r_s1_data;
    end else begin
      w_s1_data = '0;
    end
  end

  // First result stage: data and valid one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_data  <= w_s1_data;
      r_s1_valid <= i_acc;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [LEN_DATA-1:0] r_s2_data;
    logic                r_s2_valid;

    // Optional output stage: shifts the result one more cycle, never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_data  <= r_s1_data;
        r_s2_valid <= r_s1_valid;
      end
    end

    assign o_rdata  = r_s2_data;
    assign o_rvalid = r_s2_valid;
  end else begin : g_noreg
    assign o_rdata  = r_s1_data;
    assign o_rvalid = r_s1_valid;
  end

endmodule

// File: rtl/sram_dp.sv
// True dual-port, byte-writable, single-clock RAM with post-reset clear sweep.
// The INIT_FILE image is attached by the implementation flow's memory
// initialisation; it is never reloaded by reset.
module sram_dp #(
  parameter int    LEN_ADDR       = 32,
  parameter int    LEN_DATA       = 32,
  parameter int    DEPTH          = 32,
  parameter int    WRITE_MODE     = 0,
  parameter int    OUT_REG        = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     init_done,
  sram_dp_if.slave mem_bus
);
  import sram_pkg::*;

  localparam int     LANES    = LEN_DATA / 8;
  localparam int     OFF_W    = $clog2(LANES);
  localparam int     IDX_W    = $clog2(DEPTH);
  localparam state_e ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam bit     HAS_IMG  = (INIT_FILE != "");

  logic [LEN_DATA-1:0] r_mem [DEPTH];

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_init_done;

  logic [IDX_W-1:0]    w_a_idx, w_b_idx;
  logic                w_ready, w_a_acc, w_b_acc, w_a_wr, w_b_wr, w_same;
  logic [LEN_DATA-1:0] w_a_old, w_b_old, w_a_mask, w_b_mask, w_a_new, w_b_new, w_b_line;
  logic                w_unused_s;

  assign w_a_idx  = mem_bus.a_addr[OFF_W +: IDX_W];
  assign w_b_idx  = mem_bus.b_addr[OFF_W +: IDX_W];
  assign w_ready  = (r_state == ST_READY);
  assign w_a_acc  = w_ready & mem_bus.a_en;
  assign w_b_acc  = w_ready & mem_bus.b_en;
  assign w_a_wr   = w_a_acc & (|mem_bus.a_we);
  assign w_b_wr   = w_b_acc & (|mem_bus.b_we);
  assign w_a_old  = r_mem[w_a_idx];
  assign w_b_old  = r_mem[w_b_idx];
  assign w_a_mask = LEN_DATA'(byte_mask(MAX_LANES'(mem_bus.a_we)));
  assign w_b_mask = LEN_DATA'(byte_mask(MAX_LANES'(mem_bus.b_we)));
  assign w_a_new  = (w_a_old & ~w_a_mask) | (mem_bus.a_wdata & w_a_mask);
  assign w_b_new  = (w_b_old & ~w_b_mask) | (mem_bus.b_wdata & w_b_mask);
  // Both ports writing one line: A's enabled bytes override B's merge.
  assign w_same   = w_a_wr & w_b_wr & (w_a_idx == w_b_idx);
  assign w_b_line = w_same ? ((w_b_new & ~w_a_mask) | (mem_bus.a_wdata & w_a_mask)) : w_b_new;

  // Offset and upper address bits never select a line.
  assign w_unused_s = ^{mem_bus.a_addr, mem_bus.b_addr, HAS_IMG};

  // Clear sequencer next state: sweep every line once, then stay ready.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + IDX_W'(1);
        if (r_cnt == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Sequencer state, sweep counter and init_done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_READY);
    end
  end

  // Array update: clear sweep has exclusive use of the array until ready.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_b_wr) begin
        r_mem[w_b_idx] <= w_b_line;
      end
      if (w_a_wr && !w_same) begin
        r_mem[w_a_idx] <= w_a_new;
      end
    end
  end

  assign init_done = r_init_done;

  sram_port_out #(
    .LEN_DATA(LEN_DATA), .WRITE_MODE(WRITE_MODE), .OUT_REG(OUT_REG)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n), .i_acc(w_a_acc), .i_write(w_a_wr),
    .i_old(w_a_old), .i_merged(w_a_new),
    .o_rdata(mem_bus.a_rdata), .o_rvalid(mem_bus.a_rvalid)
  );

  sram_port_out #(
    .LEN_DATA(LEN_DATA), .WRITE_MODE(WRITE_MODE), .OUT_REG(OUT_REG)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n), .i_acc(w_b_acc), .i_write(w_b_wr),
    .i_old(w_b_old), .i_merged(w_b_new),
    .o_rdata(mem_bus.b_rdata), .o_rvalid(mem_bus.b_rvalid)
  );

endmodule

// File: tb/tb_sram_dp.sv
// Directed bench for sram_dp. Four instances share one stimulus stream:
// g_dut[0] write-first, [1] read-first, [2] no-change, [3] write-first with output register.
module tb_sram_dp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_en = 1'b0, b_en = 1'b0;
  logic [3:0]  a_we = 4'h0, b_we = 4'h0;
  logic [31:0] a_addr = 32'h0, b_addr = 32'h0, a_wdata = 32'h0, b_wdata = 32'h0;

  logic [31:0] a_rd [4];
  logic [31:0] b_rd [4];
  logic        a_rv [4];
  logic        b_rv [4];
  logic [3:0]  done;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_dp_if #(.LEN_ADDR(32), .LEN_DATA(32)) bus ();
    assign bus.a_en    = a_en;
    assign bus.a_we    = a_we;
    assign bus.a_addr  = a_addr;
    assign bus.a_wdata = a_wdata;
    assign bus.b_en    = b_en;
    assign bus.b_we    = b_we;
    assign bus.b_addr  = b_addr;
    assign bus.b_wdata = b_wdata;
    assign a_rd[g] = bus.a_rdata;
    assign a_rv[g] = bus.a_rvalid;
    assign b_rd[g] = bus.b_rdata;
    assign b_rv[g] = bus.b_rvalid;
    sram_dp #(
      .LEN_ADDR(32), .LEN_DATA(32), .DEPTH(32),
      .WRITE_MODE((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .OUT_REG((g == 3) ? 1 : 0), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .init_done(done[g]), .mem_bus(bus)
    );
  end

  typedef struct {
    logic        a_en;  logic [3:0] a_we; logic [31:0] a_addr; logic [31:0] a_wdata;
    logic        b_en;  logic [3:0] b_we; logic [31:0] b_addr; logic [31:0] b_wdata;
    logic        a_rv;  logic [31:0] a_d0; logic [31:0] a_d1; logic [31:0] a_d2;
    logic        b_rv;  logic [31:0] b_d0; logic [31:0] b_d1; logic [31:0] b_d2;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ae, input logic [3:0] awe, input logic [31:0] aad, input logic [31:0] awd,
                       input logic be, input logic [3:0] bwe, input logic [31:0] bad, input logic [31:0] bwd);
    a_en = ae; a_we = awe; a_addr = aad; a_wdata = awd;
    b_en = be; b_we = bwe; b_addr = bad; b_wdata = bwd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for init_done on instance 0, checking rvalid stays low meanwhile.
  task automatic wait_init(input string tag);
    int n;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk({tag, "_sweep_rvalid"}, 32'(a_rv[0]), 32'h0);
      if (done[0]) begin
        n = k;
        break;
      end
    end
    chk({tag, "_init_latency"}, 32'(n), 32'd32);
  endtask

  initial begin
    //             a_en  a_we   a_addr        a_wdata        b_en  b_we   b_addr        b_wdata        a_rv  a_d0           a_d1           a_d2           b_rv  b_d0           b_d1           b_d2
    vecs[0]  = '{1'b1, 4'hF, 32'h00000014, 32'hCAFEF00D, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 32'hCAFEF00D, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b1, 4'hF, 32'h00000010, 32'h11223344, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 32'h11223344, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[2]  = '{1'b1, 4'h0, 32'h00000014, 32'h00000000, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[3]  = '{1'b1, 4'h5, 32'h00000010, 32'hAABBCCDD, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 32'h11BB33DD, 32'h11223344, 32'hCAFEF00D, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4]  = '{1'b1, 4'h0, 32'h00000010, 32'h00000000, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[5]  = '{1'b0, 4'h0, 32'h00000010, 32'h00000000, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h11BB33DD, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[6]  = '{1'b1, 4'h3, 32'h80000088, 32'hFFFFFFFF, 1'b1, 4'hF, 32'h0000000A, 32'h12345678, 1'b1, 32'h0000FFFF, 32'h00000000, 32'h11BB33DD, 1'b1, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[7]  = '{1'b1, 4'h0, 32'h00000008, 32'h00000000, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 32'h1234FFFF, 32'h1234FFFF, 32'h1234FFFF, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[8]  = '{1'b1, 4'hF, 32'h00000060, 32'hDEADBEEF, 1'b1, 4'h0, 32'h00000060, 32'h00000000, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'h1234FFFF, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[9]  = '{1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 4'h0, 32'h00000060, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h1234FFFF, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 4'h0, 32'h00000060, 32'h00000000, 1'b1, 4'h8, 32'h00000060, 32'h01000000, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h01ADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 4'h0, 32'h00000060, 32'h00000000, 1'b1, 4'h0, 32'h0000007C, 32'h00000000, 1'b1, 32'h01ADBEEF, 32'h01ADBEEF, 32'h01ADBEEF, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000};

    // Reset values, before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_init_done", 32'(done[0]), 32'h0);
    chk("rst_a_rvalid", 32'(a_rv[0]), 32'h0);
    chk("rst_a_rdata", a_rd[0], 32'h0);
    chk("rst_b_rdata", b_rd[0], 32'h0);

    // Release with port A requesting every cycle during the sweep.
    drive(1'b1, 4'h0, 32'h7C, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    wait_init("first");
    step();
    chk("post_clear_rvalid", 32'(a_rv[0]), 32'h1);
    chk("post_clear_rdata", a_rd[0], 32'h0);
    chk("post_clear_done3", 32'(done[3]), 32'h1);

    // Table of single-cycle vectors across the three write modes.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a_en, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
            vecs[i].b_en, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
      step();
      chk($sformatf("v%0d_a_rvalid", i), 32'(a_rv[0]), 32'(vecs[i].a_rv));
      chk($sformatf("v%0d_a_rdata_wf", i), a_rd[0], vecs[i].a_d0);
      chk($sformatf("v%0d_a_rdata_rf", i), a_rd[1], vecs[i].a_d1);
      chk($sformatf("v%0d_a_rdata_nc", i), a_rd[2], vecs[i].a_d2);
      chk($sformatf("v%0d_a_rvalid_nc", i), 32'(a_rv[2]), 32'(vecs[i].a_rv));
      chk($sformatf("v%0d_b_rvalid", i), 32'(b_rv[0]), 32'(vecs[i].b_rv));
      chk($sformatf("v%0d_b_rdata_wf", i), b_rd[0], vecs[i].b_d0);
      chk($sformatf("v%0d_b_rdata_rf", i), b_rd[1], vecs[i].b_d1);
      chk($sformatf("v%0d_b_rdata_nc", i), b_rd[2], vecs[i].b_d2);
    end

    // Output-register instance: preload 1,2,3 then three back-to-back reads.
    drive(1'b1, 4'hF, 32'h0, 32'd1, 1'b0, 4'h0, 32'h0, 32'h0); step();
    drive(1'b1, 4'hF, 32'h4, 32'd2, 1'b0, 4'h0, 32'h0, 32'h0); step();
    drive(1'b1, 4'hF, 32'h8, 32'd3, 1'b0, 4'h0, 32'h0, 32'h0); step();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0); step(); step();
    chk("oreg_idle_rvalid", 32'(a_rv[3]), 32'h0);
    drive(1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0); step();
    chk("oreg_r1_rvalid", 32'(a_rv[3]), 32'h0);
    chk("oreg_r1_rdata", a_rd[3], 32'h0);
    drive(1'b1, 4'h0, 32'h4, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0); step();
    chk("oreg_r2_rvalid", 32'(a_rv[3]), 32'h1);
    chk("oreg_r2_rdata", a_rd[3], 32'd1);
    drive(1'b1, 4'h0, 32'h8, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0); step();
    chk("oreg_r3_rvalid", 32'(a_rv[3]), 32'h1);
    chk("oreg_r3_rdata", a_rd[3], 32'd2);
    chk("oreg_r3_wf_direct", a_rd[0], 32'd3);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0); step();
    chk("oreg_t4_rvalid", 32'(a_rv[3]), 32'h1);
    chk("oreg_t4_rdata", a_rd[3], 32'd3);
    step();
    chk("oreg_t5_rvalid", 32'(a_rv[3]), 32'h0);
    chk("oreg_t5_rdata", a_rd[3], 32'h0);

    // Reset asserted mid-cycle while outputs hold data, then mid-sweep at cnt=10.
    drive(1'b1, 4'h0, 32'h4, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0); step();
    chk("pre_reset_rdata", a_rd[0], 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rdata", a_rd[0], 32'h0);
    chk("async_rst_rvalid", 32'(a_rv[0]), 32'h0);
    chk("async_rst_done", 32'(done[0]), 32'h0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("partial_sweep_rvalid_%0d", k), 32'(a_rv[0]), 32'h0);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_sweep_rst_done", 32'(done[0]), 32'h0);
    chk("mid_sweep_rst_rvalid", 32'(a_rv[0]), 32'h0);
    step();
    rst_n = 1'b1;
    wait_init("second");

    // Line 24 lies beyond the partial sweep: only the full restart clears it.
    drive(1'b1, 4'h0, 32'h60, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0); step();
    chk("after_restart_a_rvalid", 32'(a_rv[0]), 32'h1);
    chk("after_restart_a_rdata", a_rd[0], 32'h0);
    chk("after_restart_b_rdata", b_rd[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
